// File: rtl/ysyx_24110006_mem_arb_if.sv
// ysyx_24110006_mem_arb_if
// Bundles the IFU, LSU and memory-side signals of the memory arbiter.
//   IFU : i_ifu_req, i_ifu_addr -> o_ifu_valid, o_ifu_rdata
//   LSU : i_lsu_req, i_lsu_wen, i_lsu_addr, i_lsu_wdata, i_lsu_wmask
//         -> o_lsu_valid, o_lsu_rdata
//   MEM : o_mem_ren, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_wmask
//         <- i_mem_done, i_mem_rdata
// Modport slave is the arbiter view; modport master is the view of the
// requesters and memory combined (used by the testbench).
// Handshake: a requester raises *_req (level) with stable fields and holds it
// until its o_*_valid pulse; the arbiter answers with exactly one
// single-cycle valid per grant and samples requests only while idle.
interface ysyx_24110006_mem_arb_if;
    logic        i_ifu_req;
    logic [31:0] i_ifu_addr;
    logic        o_ifu_valid;
    logic [31:0] o_ifu_rdata;
    logic        i_lsu_req;
    logic        i_lsu_wen;
    logic [31:0] i_lsu_addr;
    logic [31:0] i_lsu_wdata;
    logic [7:0]  i_lsu_wmask;
    logic        o_lsu_valid;
    logic [31:0] o_lsu_rdata;
    logic        o_mem_ren;
    logic        o_mem_wen;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [7:0]  o_mem_wmask;
    logic        i_mem_done;
    logic [31:0] i_mem_rdata;

    modport slave (
        input  i_ifu_req, i_ifu_addr,
        output o_ifu_valid, o_ifu_rdata,
        input  i_lsu_req, i_lsu_wen, i_lsu_addr, i_lsu_wdata, i_lsu_wmask,
        output o_lsu_valid, o_lsu_rdata,
        output o_mem_ren, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_wmask,
        input  i_mem_done, i_mem_rdata
    );

    modport master (
        output i_ifu_req, i_ifu_addr,
        input  o_ifu_valid, o_ifu_rdata,
        output i_lsu_req, i_lsu_wen, i_lsu_addr, i_lsu_wdata, i_lsu_wmask,
        input  o_lsu_valid, o_lsu_rdata,
        input  o_mem_ren, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_wmask,
        output i_mem_done, i_mem_rdata
    );
endinterface

// File: rtl/ysyx_24110006_mem_arb.sv
// ysyx_24110006_mem_arb
// Two-requester (IFU, LSU) arbiter in front of a single-outstanding memory.
// Ports:
//   i_clock  : clock, all state changes on posedge
//   i_reset  : synchronous, active-high reset
//   bus      : ysyx_24110006_mem_arb_if.slave (IFU/LSU/memory signals)
//   o_busy   : high in every state except IDLE
//   o_state  : current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP)
// Configuration macro: YSYX_24110006_ARB_RR_EN
//   defined   -> round-robin between IFU and LSU on simultaneous requests
//   undefined -> fixed priority, LSU over IFU
// Every output is a register; the always_comb block computes next values.
module ysyx_24110006_mem_arb (
    input  logic                         i_clock,
    input  logic                         i_reset,
    ysyx_24110006_mem_arb_if.slave       bus,
    output logic                         o_busy,
    output logic [1:0]                   o_state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state, w_state_next;
    logic        r_grant_lsu, w_grant_lsu_next;
    logic        r_is_write, w_is_write_next;
    logic        r_mem_ren, w_mem_ren_next;
    logic        r_mem_wen, w_mem_wen_next;
    logic [31:0] r_mem_addr, w_mem_addr_next;
    logic [31:0] r_mem_wdata, w_mem_wdata_next;
    logic [7:0]  r_mem_wmask, w_mem_wmask_next;
    logic        r_ifu_valid, w_ifu_valid_next;
    logic [31:0] r_ifu_rdata, w_ifu_rdata_next;
    logic        r_lsu_valid, w_lsu_valid_next;
    logic [31:0] r_lsu_rdata, w_lsu_rdata_next;
    logic        r_busy;

    logic w_any_req;
    logic w_both_pick_lsu;
    logic w_grant_lsu;

    assign w_any_req   = bus.i_ifu_req | bus.i_lsu_req;
    // LSU wins when it is the only requester, or when both ask and the
    // arbitration policy picks it.
    assign w_grant_lsu = bus.i_lsu_req & (~bus.i_ifu_req | w_both_pick_lsu);

`ifdef YSYX_24110006_ARB_RR_EN
    // Remembers who was granted last; reset value means "IFU last", so the
    // first contested grant goes to the LSU.
    logic r_last_lsu;
    assign w_both_pick_lsu = ~r_last_lsu;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_last_lsu <= 1'b0;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last_lsu <= w_grant_lsu;
        end
    end
`else
    assign w_both_pick_lsu = 1'b1;
`endif

    always_comb begin
        w_state_next     = r_state;
        w_grant_lsu_next = r_grant_lsu;
        w_is_write_next  = r_is_write;
        w_mem_ren_next   = 1'b0;
        w_mem_wen_next   = 1'b0;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_mem_wmask_next = r_mem_wmask;
        w_ifu_valid_next = 1'b0;
        w_ifu_rdata_next = r_ifu_rdata;
        w_lsu_valid_next = 1'b0;
        w_lsu_rdata_next = r_lsu_rdata;

        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_next     = S_ISSUE;
                    w_grant_lsu_next = w_grant_lsu;
                    w_is_write_next  = w_grant_lsu & bus.i_lsu_wen;
                    w_mem_addr_next  = w_grant_lsu ? bus.i_lsu_addr  : bus.i_ifu_addr;
                    w_mem_wdata_next = w_grant_lsu ? bus.i_lsu_wdata : 32'd0;
                    w_mem_wmask_next = w_grant_lsu ? bus.i_lsu_wmask : 8'd0;
                    // The strobe for the ISSUE cycle is set on entry.
                    w_mem_wen_next   = w_grant_lsu & bus.i_lsu_wen;
                    w_mem_ren_next   = ~(w_grant_lsu & bus.i_lsu_wen);
                end
            end
            // ISSUE and WAIT behave alike: completion moves to RESP,
            // otherwise keep waiting with fields held.
            S_ISSUE, S_WAIT: begin
                if (bus.i_mem_done) begin
                    w_state_next     = S_RESP;
                    w_mem_addr_next  = 32'd0;
                    w_mem_wdata_next = 32'd0;
                    w_mem_wmask_next = 8'd0;
                    if (r_grant_lsu) begin
                        w_lsu_valid_next = 1'b1;
                        if (!r_is_write) begin
                            w_lsu_rdata_next = bus.i_mem_rdata;
                        end
                    end else begin
                        w_ifu_valid_next = 1'b1;
                        w_ifu_rdata_next = bus.i_mem_rdata;
                    end
                end else begin
                    w_state_next = S_WAIT;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_grant_lsu <= 1'b0;
            r_is_write  <= 1'b0;
            r_mem_ren   <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_wmask <= 8'd0;
            r_ifu_valid <= 1'b0;
            r_ifu_rdata <= 32'd0;
            r_lsu_valid <= 1'b0;
            r_lsu_rdata <= 32'd0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_grant_lsu <= w_grant_lsu_next;
            r_is_write  <= w_is_write_next;
            r_mem_ren   <= w_mem_ren_next;
            r_mem_wen   <= w_mem_wen_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_mem_wmask <= w_mem_wmask_next;
            r_ifu_valid <= w_ifu_valid_next;
            r_ifu_rdata <= w_ifu_rdata_next;
            r_lsu_valid <= w_lsu_valid_next;
            r_lsu_rdata <= w_lsu_rdata_next;
            r_busy      <= (w_state_next != S_IDLE);
        end
    end

    assign bus.o_ifu_valid = r_ifu_valid;
    assign bus.o_ifu_rdata = r_ifu_rdata;
    assign bus.o_lsu_valid = r_lsu_valid;
    assign bus.o_lsu_rdata = r_lsu_rdata;
    assign bus.o_mem_ren   = r_mem_ren;
    assign bus.o_mem_wen   = r_mem_wen;
    assign bus.o_mem_addr  = r_mem_addr;
    assign bus.o_mem_wdata = r_mem_wdata;
    assign bus.o_mem_wmask = r_mem_wmask;
    assign o_busy          = r_busy;
    assign o_state         = r_state;
endmodule

// File: tb/tb_ysyx_24110006_mem_arb.sv
module tb_ysyx_24110006_mem_arb;
  logic       clk;
  logic       rst;
  logic       busy;
  logic [1:0] state;
  int         n_pass;
  int         n_total;
  logic       exp_lsu;

  ysyx_24110006_mem_arb_if bus ();

  ysyx_24110006_mem_arb dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.slave),
    .o_busy  (busy),
    .o_state (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".state"}, {30'd0, state}, 32'd0);
    check({tag, ".busy"}, {31'd0, busy}, 32'd0);
    check({tag, ".ren"}, {31'd0, bus.o_mem_ren}, 32'd0);
    check({tag, ".wen"}, {31'd0, bus.o_mem_wen}, 32'd0);
    check({tag, ".addr"}, bus.o_mem_addr, 32'd0);
    check({tag, ".wdata"}, bus.o_mem_wdata, 32'd0);
    check({tag, ".wmask"}, {24'd0, bus.o_mem_wmask}, 32'd0);
    check({tag, ".ifu_valid"}, {31'd0, bus.o_ifu_valid}, 32'd0);
    check({tag, ".lsu_valid"}, {31'd0, bus.o_lsu_valid}, 32'd0);
    check({tag, ".ifu_rdata"}, bus.o_ifu_rdata, 32'd0);
    check({tag, ".lsu_rdata"}, bus.o_lsu_rdata, 32'd0);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    bus.i_ifu_req   = 1'b0;
    bus.i_ifu_addr  = 32'd0;
    bus.i_lsu_req   = 1'b0;
    bus.i_lsu_wen   = 1'b0;
    bus.i_lsu_addr  = 32'd0;
    bus.i_lsu_wdata = 32'd0;
    bus.i_lsu_wmask = 8'd0;
    bus.i_mem_done  = 1'b0;
    bus.i_mem_rdata = 32'd0;

    // reset state
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // IFU-only read, done during ISSUE
    bus.i_ifu_req  = 1'b1;
    bus.i_ifu_addr = 32'h8000_0000;
    tick();
    check("ifu.issue_state", {30'd0, state}, 32'd1);
    check("ifu.issue_ren", {31'd0, bus.o_mem_ren}, 32'd1);
    check("ifu.issue_wen", {31'd0, bus.o_mem_wen}, 32'd0);
    check("ifu.issue_addr", bus.o_mem_addr, 32'h8000_0000);
    check("ifu.issue_busy", {31'd0, busy}, 32'd1);
    bus.i_mem_done  = 1'b1;
    bus.i_mem_rdata = 32'h1234_5678;
    tick();
    check("ifu.resp_valid", {31'd0, bus.o_ifu_valid}, 32'd1);
    check("ifu.resp_rdata", bus.o_ifu_rdata, 32'h1234_5678);
    check("ifu.resp_lsu_valid", {31'd0, bus.o_lsu_valid}, 32'd0);
    check("ifu.resp_ren", {31'd0, bus.o_mem_ren}, 32'd0);
    bus.i_mem_done = 1'b0;
    bus.i_ifu_req  = 1'b0;
    tick();
    check("ifu.idle_state", {30'd0, state}, 32'd0);
    check("ifu.idle_valid", {31'd0, bus.o_ifu_valid}, 32'd0);
    check("ifu.idle_busy", {31'd0, busy}, 32'd0);
    check("ifu.idle_addr", bus.o_mem_addr, 32'd0);
    check("ifu.rdata_hold", bus.o_ifu_rdata, 32'h1234_5678);

    // LSU read (sets o_lsu_rdata), done one cycle late
    bus.i_lsu_req  = 1'b1;
    bus.i_lsu_wen  = 1'b0;
    bus.i_lsu_addr = 32'h8000_0020;
    tick();
    check("lsur.issue_ren", {31'd0, bus.o_mem_ren}, 32'd1);
    check("lsur.issue_addr", bus.o_mem_addr, 32'h8000_0020);
    tick();
    check("lsur.wait_state", {30'd0, state}, 32'd2);
    check("lsur.wait_ren", {31'd0, bus.o_mem_ren}, 32'd0);
    bus.i_mem_done  = 1'b1;
    bus.i_mem_rdata = 32'h0BAD_C0DE;
    tick();
    check("lsur.resp_valid", {31'd0, bus.o_lsu_valid}, 32'd1);
    check("lsur.resp_rdata", bus.o_lsu_rdata, 32'h0BAD_C0DE);
    check("lsur.resp_ifu_valid", {31'd0, bus.o_ifu_valid}, 32'd0);
    bus.i_mem_done = 1'b0;
    bus.i_lsu_req  = 1'b0;
    tick();

    // LSU write: strobe and fields, rdata untouched
    bus.i_lsu_req   = 1'b1;
    bus.i_lsu_wen   = 1'b1;
    bus.i_lsu_addr  = 32'h8000_0010;
    bus.i_lsu_wdata = 32'hDEAD_BEEF;
    bus.i_lsu_wmask = 8'h0F;
    tick();
    check("lsuw.issue_wen", {31'd0, bus.o_mem_wen}, 32'd1);
    check("lsuw.issue_ren", {31'd0, bus.o_mem_ren}, 32'd0);
    check("lsuw.issue_addr", bus.o_mem_addr, 32'h8000_0010);
    check("lsuw.issue_wdata", bus.o_mem_wdata, 32'hDEAD_BEEF);
    check("lsuw.issue_wmask", {24'd0, bus.o_mem_wmask}, 32'h0000_000F);
    tick();
    check("lsuw.wait_wen", {31'd0, bus.o_mem_wen}, 32'd0);
    check("lsuw.wait_wdata", bus.o_mem_wdata, 32'hDEAD_BEEF);
    bus.i_mem_done  = 1'b1;
    bus.i_mem_rdata = 32'hCAFE_F00D;
    tick();
    check("lsuw.resp_valid", {31'd0, bus.o_lsu_valid}, 32'd1);
    check("lsuw.rdata_kept", bus.o_lsu_rdata, 32'h0BAD_C0DE);
    check("lsuw.ifu_rdata_kept", bus.o_ifu_rdata, 32'h1234_5678);
    bus.i_mem_done = 1'b0;
    bus.i_lsu_req  = 1'b0;
    bus.i_lsu_wen  = 1'b0;
    tick();
    check("lsuw.idle_valid", {31'd0, bus.o_lsu_valid}, 32'd0);

    // Both requesting from a fresh reset, four transactions
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_ifu_req  = 1'b1;
    bus.i_ifu_addr = 32'h0000_0100;
    bus.i_lsu_req  = 1'b1;
    bus.i_lsu_wen  = 1'b0;
    bus.i_lsu_addr = 32'h0000_0200;
    for (int k = 0; k < 4; k++) begin
`ifdef YSYX_24110006_ARB_RR_EN
      exp_lsu = (k % 2 == 0);
`else
      exp_lsu = 1'b1;
`endif
      tick();
      check($sformatf("arb%0d.addr", k), bus.o_mem_addr, exp_lsu ? 32'h0000_0200 : 32'h0000_0100);
      bus.i_mem_done  = 1'b1;
      bus.i_mem_rdata = 32'hA000_0000 + 32'(k);
      tick();
      check($sformatf("arb%0d.lsu_valid", k), {31'd0, bus.o_lsu_valid}, {31'd0, exp_lsu});
      check($sformatf("arb%0d.ifu_valid", k), {31'd0, bus.o_ifu_valid}, {31'd0, ~exp_lsu});
      check($sformatf("arb%0d.rdata", k), exp_lsu ? bus.o_lsu_rdata : bus.o_ifu_rdata,
            32'hA000_0000 + 32'(k));
      bus.i_mem_done = 1'b0;
      tick();
    end
    bus.i_ifu_req = 1'b0;
    bus.i_lsu_req = 1'b0;
    tick();

    // Memory completion delayed 10 cycles
    bus.i_ifu_req  = 1'b1;
    bus.i_ifu_addr = 32'h8000_0040;
    tick();
    check("slow.issue_ren", {31'd0, bus.o_mem_ren}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("slow%0d.busy", i), {31'd0, busy}, 32'd1);
      check($sformatf("slow%0d.addr", i), bus.o_mem_addr, 32'h8000_0040);
      check($sformatf("slow%0d.ren", i), {31'd0, bus.o_mem_ren}, 32'd0);
      check($sformatf("slow%0d.valid", i), {31'd0, bus.o_ifu_valid}, 32'd0);
    end
    bus.i_mem_done  = 1'b1;
    bus.i_mem_rdata = 32'h55AA_55AA;
    tick();
    check("slow.resp_valid", {31'd0, bus.o_ifu_valid}, 32'd1);
    check("slow.resp_rdata", bus.o_ifu_rdata, 32'h55AA_55AA);
    bus.i_mem_done = 1'b0;
    bus.i_ifu_req  = 1'b0;
    tick();
    check("slow.idle_valid", {31'd0, bus.o_ifu_valid}, 32'd0);
    check("slow.idle_busy", {31'd0, busy}, 32'd0);

    // Reset while waiting abandons the access
    bus.i_lsu_req  = 1'b1;
    bus.i_lsu_wen  = 1'b0;
    bus.i_lsu_addr = 32'h8000_0050;
    tick();
    tick();
    check("rstw.wait_state", {30'd0, state}, 32'd2);
    rst = 1'b1;
    tick();
    check_all_zero("rstw");
    rst = 1'b0;
    bus.i_lsu_req   = 1'b0;
    bus.i_mem_done  = 1'b1;
    bus.i_mem_rdata = 32'h7777_7777;
    tick();
    check("rstw.late_lsu_valid", {31'd0, bus.o_lsu_valid}, 32'd0);
    check("rstw.late_state", {30'd0, state}, 32'd0);
    bus.i_mem_done = 1'b0;
    tick();
    check("rstw.late_lsu_valid2", {31'd0, bus.o_lsu_valid}, 32'd0);
    check("rstw.late_lsu_rdata", bus.o_lsu_rdata, 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
